// File: rtl/epl_ecc_pkg.sv
// Shared SECDED helpers for the EPL ECC read and write paths: code geometry,
// data-bit placement and the decoder's classification of a received word.
package epl_ecc_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN,
    ECC_CORR,
    ECC_PARFIX,
    ECC_UNCORR
  } ecc_class_t;

  // Ceiling on any codeword this package has to describe (64 data bits -> 72).
  localparam int unsigned EccMaxCodeW = 128;

  // Smallest r with 2^r >= dataW + r + 1.
  function automatic int unsigned ecc_par_w(input int unsigned dataW);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < 8; k++) begin
      if ((32'd1 << r) < dataW + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // Codeword index of data bit i: the i-th Hamming position that is not a power of two.
  function automatic int unsigned ecc_data_idx(input int unsigned i);
    int unsigned cnt;
    int unsigned idx;
    logic        found;
    cnt   = 0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned p = 1; p < EccMaxCodeW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (!found && cnt == i) begin
          idx   = p - 1;
          found = 1'b1;
        end
        cnt = cnt + 1;
      end
    end
    return idx;
  endfunction

  // Codeword indices covered by syndrome bit k (positions with bit k set).
  function automatic logic [EccMaxCodeW-1:0] ecc_cover_mask(input int unsigned k);
    logic [EccMaxCodeW-1:0] m;
    m = '0;
    for (int unsigned p = 1; p < EccMaxCodeW; p++) begin
      if (((p >> k) & 32'd1) != 32'd0) m = m | (EccMaxCodeW'(1) << (p - 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/epl_ecc_syndrome.sv
// Combinational SECDED checker: Hamming syndrome and overall parity of a codeword,
// with the stored-complement convention folded in.
module epl_ecc_syndrome
  import epl_ecc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter bit          PAR_INV = 1'b1,
  localparam int unsigned ParW   = ecc_par_w(DATA_W),
  localparam int unsigned CodeW  = DATA_W + ParW + 1
) (
  input  logic [CodeW-1:0] pCODE_i,
  output logic [ParW-1:0]  pSYND_c,
  output logic             pPAR_c
);

  for (genvar k = 0; k < ParW; k++) begin : gSynd
    localparam logic [EccMaxCodeW-1:0] CovMask = ecc_cover_mask(k);
    assign pSYND_c[k] = (^(pCODE_i & CovMask[CodeW-1:0])) ^ PAR_INV;
  end

  assign pPAR_c = (^pCODE_i) ^ PAR_INV;

endmodule

// File: rtl/epl_secded_decoder.sv
// Parametrised SECDED decoder for the EPL ECC read path: two-stage valid/ready
// pipeline with single-error correction, double-error detection and error counters.
module epl_secded_decoder
  import epl_ecc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter bit          PAR_INV = 1'b1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ParW   = ecc_par_w(DATA_W),
  localparam int unsigned CodeW  = DATA_W + ParW + 1
) (
  input  logic              pCLK_i,
  input  logic              nRST_i,
  input  logic              pVALID_i,
  output logic              pREADY_o,
  input  logic [CodeW-1:0]  pCODE_i,
  output logic              pVALID_o,
  input  logic              pREADY_i,
  output logic [DATA_W-1:0] pDATA_o,
  output logic              pCORR_o,
  output logic              pUNCORR_o,
  output logic [ParW-1:0]   pSYND_o,
  input  logic              pCNTCLR_i,
  output logic [CNT_W-1:0]  pCORRCNT_o,
  output logic [CNT_W-1:0]  pUNCORRCNT_o
);

  logic              v1;
  logic [DATA_W-1:0] data1;
  logic [ParW-1:0]   synd1;
  logic              par1;

  logic [ParW-1:0]   syndIn;
  logic              parIn;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataFix;
  ecc_class_t        cls;

  logic accept;
  logic load2;
  logic outHs;

  epl_ecc_syndrome #(
    .DATA_W  (DATA_W),
    .PAR_INV (PAR_INV)
  ) uSynd (
    .pCODE_i (pCODE_i),
    .pSYND_c (syndIn),
    .pPAR_c  (parIn)
  );

  // A stage loads when empty or when its occupant leaves in the same cycle.
  assign pREADY_o = !v1 || !pVALID_o || pREADY_i;
  assign accept   = pVALID_i && pREADY_o;
  assign load2    = v1 && (!pVALID_o || pREADY_i);
  assign outHs    = pVALID_o && pREADY_i;

  // Check bits are fully summarised by S and P, so stage 1 keeps only the data field.
  for (genvar i = 0; i < DATA_W; i++) begin : gExtract
    localparam int unsigned DIdx = ecc_data_idx(i);
    assign dataIn[i] = pCODE_i[DIdx];
  end

  always_ff @(posedge pCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      v1    <= 1'b0;
      data1 <= '0;
      synd1 <= '0;
      par1  <= 1'b0;
    end else if (accept) begin
      v1    <= 1'b1;
      data1 <= dataIn;
      synd1 <= syndIn;
      par1  <= parIn;
    end else if (load2) begin
      v1    <= 1'b0;
    end
  end

  // Classify the stage-1 word from its syndrome and overall parity.
  always_comb begin
    cls = ECC_CLEAN;
    if (par1) begin
      if (synd1 == '0) begin
        cls = ECC_PARFIX;
      end else if (32'(synd1) <= CodeW - 1) begin
        cls = ECC_CORR;
      end else begin
        cls = ECC_UNCORR;
      end
    end else if (synd1 != '0) begin
      cls = ECC_UNCORR;
    end
  end

  // A syndrome naming a check-bit position corrects nothing in the data field.
  for (genvar i = 0; i < DATA_W; i++) begin : gFix
    localparam int unsigned DPos = ecc_data_idx(i) + 1;
    assign dataFix[i] = data1[i] ^ ((cls == ECC_CORR) && (32'(synd1) == DPos));
  end

  always_ff @(posedge pCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      pVALID_o  <= 1'b0;
      pDATA_o   <= '0;
      pCORR_o   <= 1'b0;
      pUNCORR_o <= 1'b0;
      pSYND_o   <= '0;
    end else if (load2) begin
      pVALID_o  <= 1'b1;
      pDATA_o   <= dataFix;
      pCORR_o   <= (cls == ECC_CORR) || (cls == ECC_PARFIX);
      pUNCORR_o <= (cls == ECC_UNCORR);
      pSYND_o   <= synd1;
    end else if (pREADY_i) begin
      pVALID_o  <= 1'b0;
    end
  end

  // Saturating event counters; a clear overrides a same-cycle increment.
  always_ff @(posedge pCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      pCORRCNT_o   <= '0;
      pUNCORRCNT_o <= '0;
    end else if (pCNTCLR_i) begin
      pCORRCNT_o   <= '0;
      pUNCORRCNT_o <= '0;
    end else if (outHs) begin
      if (pCORR_o && (pCORRCNT_o != {CNT_W{1'b1}})) begin
        pCORRCNT_o <= pCORRCNT_o + CNT_W'(1);
      end
      if (pUNCORR_o && (pUNCORRCNT_o != {CNT_W{1'b1}})) begin
        pUNCORRCNT_o <= pUNCORRCNT_o + CNT_W'(1);
      end
    end
  end

endmodule
